// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous memory between
// instruction fetch (IF, read only) and the load/store path (DM).
//
// DM wins contested cycles until IF has lost STARVE_MAX contested grants
// in a row, then IF is forced through. One transaction in flight.
//
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   if_req/if_addr          IF read request (level, held until if_gnt)
//   if_gnt                  IF accepted (combinational, IDLE only)
//   if_rvalid/if_rdata      IF read response (pulse / held data)
//   dm_req/dm_we/dm_addr/dm_wdata  DM request (level, held until dm_gnt)
//   dm_gnt                  DM accepted (combinational, IDLE only)
//   dm_rvalid/dm_rdata      DM read response (pulse / held data)
//   mem_en/mem_we/mem_addr/mem_wdata  registered memory strobe + payload
//   mem_rdata               memory data, valid MEM_LAT cycles after mem_en
//   busy                    high whenever not IDLE
//
// Optional feature: define MEMARB_PERF_EN to add conflict_cnt[15:0],
// a saturating count of IDLE cycles with both requests raised.

module mem_port_arbiter #(
    parameter int AW         = 8,
    parameter int DW         = 16,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 3
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_gnt,
    output logic          dm_rvalid,
    output logic [DW-1:0] dm_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
`ifdef MEMARB_PERF_EN
    output logic [15:0]   conflict_cnt,
`endif
    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT
    } state_t;

    state_t        state_q, state_d;
    logic          owner_dm_q, owner_dm_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [3:0]    starve_q, starve_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          if_rvalid_q, if_rvalid_d;
    logic          dm_rvalid_q, dm_rvalid_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] dm_rdata_q, dm_rdata_d;
    logic          starve_hit;

    assign starve_hit = (starve_q == 4'(STARVE_MAX));

    always_comb begin
        state_d     = state_q;
        owner_dm_d  = owner_dm_q;
        cnt_d       = cnt_q;
        starve_d    = starve_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rvalid_d = 1'b0;
        dm_rvalid_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_gnt      = 1'b0;
        dm_gnt      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // IF beats DM only once it has been starved long enough
                if (dm_req && !(if_req && starve_hit)) begin
                    dm_gnt      = 1'b1;
                    owner_dm_d  = 1'b1;
                    mem_en_d    = 1'b1;
                    mem_we_d    = dm_we;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                    state_d     = S_ACCESS;
                    if (if_req && !starve_hit) begin
                        starve_d = starve_q + 4'd1;
                    end
                end else if (if_req) begin
                    if_gnt      = 1'b1;
                    owner_dm_d  = 1'b0;
                    mem_en_d    = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    starve_d    = 4'd0;
                    state_d     = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (mem_we_q) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = 3'(MEM_LAT);
                end
            end
            S_WAIT: begin
                if (cnt_q == 3'd1) begin
                    state_d = S_IDLE;
                    if (owner_dm_q) begin
                        dm_rdata_d  = mem_rdata;
                        dm_rvalid_d = 1'b1;
                    end else begin
                        if_rdata_d  = mem_rdata;
                        if_rvalid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            owner_dm_q  <= 1'b0;
            cnt_q       <= 3'd0;
            starve_q    <= 4'd0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_dm_q  <= owner_dm_d;
            cnt_q       <= cnt_d;
            starve_q    <= starve_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rvalid_q <= if_rvalid_d;
            dm_rvalid_q <= dm_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

`ifdef MEMARB_PERF_EN
    logic [15:0] conflict_q, conflict_d;

    always_comb begin
        conflict_d = conflict_q;
        if (state_q == S_IDLE && if_req && dm_req
            && conflict_q != 16'hFFFF) begin
            conflict_d = conflict_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            conflict_q <= 16'd0;
        end else begin
            conflict_q <= conflict_d;
        end
    end

    assign conflict_cnt = conflict_q;
`endif

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rvalid = if_rvalid_q;
    assign dm_rvalid = dm_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign busy      = (state_q != S_IDLE);

endmodule
